// File: rtl/matrix_ser_pkg.sv
// ============================================================================
// matrix_ser_pkg : shared types and helpers for the matrix frame serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package matrix_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int syms_per_elem(input int elem_w, input int sym_w);
    return elem_w / sym_w;
  endfunction

  function automatic int frame_syms(input int n, input int elem_w, input int sym_w);
    return n * n * syms_per_elem(elem_w, sym_w);
  endfunction

  // RAM address = {bank, row, col}; transpose swaps the roles of row and col
  function automatic int addr_compose(input int addr_w, input logic bank,
                                      input int row, input int col,
                                      input logic transpose);
    int r;
    int c;
    r = transpose ? col : row;
    c = transpose ? row : col;
    return (int'(bank) << (2 * addr_w)) | (r << addr_w) | c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_bank_ram.sv
// ============================================================================
// matrix_bank_ram : simple dual-port RAM, one write port, one registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_bank_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/matrix_frame_serializer.sv
// ============================================================================
// matrix_frame_serializer : double-buffered N x N matrix store streamed out
//                           as a gap-free run of SYM_W-bit symbols
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_frame_serializer
  import matrix_ser_pkg::*;
#(
  parameter int N      = 32,
  parameter int ELEM_W = 8,
  parameter int SYM_W  = 2,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_data_in,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic [ELEM_W-1:0] matrix_element,
  input  logic              commit,
  input  logic              transpose,
  input  logic              data_request,
  output logic [SYM_W-1:0]  sym_out,
  output logic              valid_data_out,
  output logic              busy,
  output logic              frame_done,
  output logic              bank_ready,
  output logic              commit_drop
);

  localparam int SYMS_PER_ELEM = syms_per_elem(ELEM_W, SYM_W);
  localparam int FRAME_SYMS    = frame_syms(N, ELEM_W, SYM_W);
  localparam int EW            = 2 * ADDR_W;
  localparam int SC_W          = (SYMS_PER_ELEM > 1) ? $clog2(SYMS_PER_ELEM) : 1;
  localparam int RAM_AW        = EW + 1;

  state_t            state, state_nx;
  logic              wr_bank;
  logic              pending;
  logic              ready_r;
  logic              tr_lat;
  logic [EW-1:0]     elem_cnt;
  logic [SC_W-1:0]   sym_cnt;
  logic [ELEM_W-1:0] shreg;
  logic [ELEM_W-1:0] rd_data;

  logic              accept;
  logic              last_sym;
  logic              elem_end;
  logic              do_swap;
  logic              rd_en;
  logic [EW-1:0]     rd_elem;
  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] wr_addr;

  assign elem_end = (sym_cnt == SC_W'(SYMS_PER_ELEM - 1));
  assign last_sym = (state == STREAM) && (elem_cnt == EW'(N * N - 1)) && elem_end;
  assign accept   = (state == IDLE) && data_request && (ready_r || commit);
  // A commit landing on the last symbol needs no wait: the reader is already done
  assign do_swap  = (commit && (state == IDLE)) || (last_sym && (pending || commit));

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_elem  = '0;
    case (state)
      IDLE: if (accept) state_nx = FETCH;
      FETCH: begin
        rd_en    = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        // prefetch the next element while the current one is being unloaded
        rd_en   = (sym_cnt == '0);
        rd_elem = elem_cnt + EW'(1);
        if (last_sym) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_addr = RAM_AW'(addr_compose(ADDR_W, ~wr_bank, int'(rd_elem[EW-1:ADDR_W]),
                                        int'(rd_elem[ADDR_W-1:0]), tr_lat));
  assign wr_addr = RAM_AW'(addr_compose(ADDR_W, wr_bank, int'(row_addr),
                                        int'(col_addr), 1'b0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_bank  <= 1'b0;
      pending  <= 1'b0;
      ready_r  <= 1'b0;
      tr_lat   <= 1'b0;
      elem_cnt <= '0;
      sym_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nx;
      if (accept) tr_lat <= transpose;
      if (do_swap) begin
        wr_bank <= ~wr_bank;
        ready_r <= 1'b1;
      end
      if (last_sym)
        pending <= 1'b0;
      else if (commit && (state != IDLE))
        pending <= 1'b1;
      if (state == STREAM) begin
        if (elem_end) begin
          sym_cnt  <= '0;
          elem_cnt <= elem_cnt + EW'(1);
        end else begin
          sym_cnt <= sym_cnt + SC_W'(1);
        end
        shreg <= (sym_cnt == '0) ? (rd_data >> SYM_W) : (shreg >> SYM_W);
      end else begin
        sym_cnt  <= '0;
        elem_cnt <= '0;
      end
    end
  end

  matrix_bank_ram #(
    .DEPTH (2 * N * N),
    .WIDTH (ELEM_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (valid_data_in),
    .waddr (wr_addr),
    .wdata (matrix_element),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign valid_data_out = (state == STREAM);
  assign sym_out        = !valid_data_out ? '0 :
                          (sym_cnt == '0) ? rd_data[SYM_W-1:0] : shreg[SYM_W-1:0];
  assign busy           = (state != IDLE);
  assign frame_done     = last_sym;
  assign bank_ready     = ready_r;
  assign commit_drop    = commit && pending;

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_serializer.sv
// ============================================================================
// tb_matrix_frame_serializer : directed, table-driven bench for the serializer
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_matrix_frame_serializer;

  localparam int N  = 32;
  localparam int FS = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_data_in;
  logic [4:0] row_addr, col_addr;
  logic [7:0] matrix_element;
  logic       commit, transpose, data_request;
  logic [1:0] sym_out;
  logic       valid_data_out, busy, frame_done, bank_ready, commit_drop;

  logic       s_vin;
  logic [1:0] s_row, s_col;
  logic [3:0] s_elem;
  logic       s_commit, s_tr, s_req;
  logic [3:0] s_sym;
  logic       s_vout, s_busy, s_done, s_ready, s_drop;

  always #5 clk = ~clk;

  matrix_frame_serializer #(.N(32), .ELEM_W(8), .SYM_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_data_in(valid_data_in), .row_addr(row_addr),
    .col_addr(col_addr), .matrix_element(matrix_element), .commit(commit),
    .transpose(transpose), .data_request(data_request), .sym_out(sym_out),
    .valid_data_out(valid_data_out), .busy(busy), .frame_done(frame_done),
    .bank_ready(bank_ready), .commit_drop(commit_drop)
  );

  matrix_frame_serializer #(.N(4), .ELEM_W(4), .SYM_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_data_in(s_vin), .row_addr(s_row),
    .col_addr(s_col), .matrix_element(s_elem), .commit(s_commit),
    .transpose(s_tr), .data_request(s_req), .sym_out(s_sym),
    .valid_data_out(s_vout), .busy(s_busy), .frame_done(s_done),
    .bank_ready(s_ready), .commit_drop(s_drop)
  );

  typedef struct {
    int frame;  // 0 = identity row-major, 1 = pattern transposed
    int idx;
    int exp;
  } vec_t;

  vec_t       tv[20];
  int         sm_exp[16];
  int         checks = 0;
  int         passed = 0;
  logic [1:0] cap [FS];
  int         nvalid, first_lat, done_at, done_cnt, idle_nz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [7:0] val(input int mode, input int r, input int c);
    case (mode)
      0:       return (r == c) ? 8'hAA : 8'hF0;
      1:       return {r[3:0], c[3:0]};
      default: return 8'h55;
    endcase
  endfunction

  function automatic int frame_errs(input int mode, input logic tr);
    int errs = 0;
    for (int i = 0; i < FS; i++) begin
      int e, k, r, c;
      logic [7:0] v;
      logic [1:0] ex;
      e  = i / 4;
      k  = i % 4;
      r  = tr ? (e % N) : (e / N);
      c  = tr ? (e / N) : (e % N);
      v  = val(mode, r, c);
      ex = 2'(v >> (2 * k));
      if (cap[i] !== ex) errs++;
    end
    return errs;
  endfunction

  task automatic write_matrix(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        valid_data_in  = 1'b1;
        row_addr       = r[4:0];
        col_addr       = c[4:0];
        matrix_element = val(mode, r, c);
      end
    @(negedge clk);
    valid_data_in = 1'b0;
  endtask

  task automatic pulse_commit(output logic drop);
    @(negedge clk);
    commit = 1'b1;
    #1 drop = commit_drop;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic run_frame(input logic tr, input int limit);
    int cyc;
    for (int i = 0; i < FS; i++) cap[i] = 'x;
    nvalid = 0; first_lat = -1; done_at = -1; done_cnt = 0; idle_nz = 0;
    @(negedge clk);
    data_request = 1'b1;
    transpose    = tr;
    @(negedge clk);
    data_request = 1'b0;
    cyc = 1;
    while (cyc < limit) begin
      if (valid_data_out) begin
        if (first_lat < 0) first_lat = cyc;
        if (nvalid < FS) cap[nvalid] = sym_out;
        nvalid++;
        if (frame_done) begin
          done_cnt++;
          done_at = nvalid;
        end
      end else begin
        if (frame_done) done_cnt++;
        if (sym_out != 0) idle_nz++;
        if (first_lat >= 0) break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic watch_idle(input int n, output logic saw);
    saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (valid_data_out || busy) saw = 1'b1;
    end
  endtask

  task automatic check_frame_shape(input string tag);
    chk({tag, "_latency"}, first_lat, 2);
    chk({tag, "_len"}, nvalid, FS);
    chk({tag, "_done_pos"}, done_at, FS);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_idle_sym0"}, idle_nz, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic d1, d2, saw;
    int   cnt, k;

    tv[0]  = '{0, 0, 2};    tv[1]  = '{0, 3, 2};    tv[2]  = '{0, 4, 0};
    tv[3]  = '{0, 5, 0};    tv[4]  = '{0, 6, 3};    tv[5]  = '{0, 7, 3};
    tv[6]  = '{0, 130, 3};  tv[7]  = '{0, 132, 2};  tv[8]  = '{0, 4091, 3};
    tv[9]  = '{0, 4095, 2};
    tv[10] = '{1, 4, 0};    tv[11] = '{1, 5, 0};    tv[12] = '{1, 6, 1};
    tv[13] = '{1, 7, 0};    tv[14] = '{1, 128, 1};  tv[15] = '{1, 10, 2};
    tv[16] = '{1, 2196, 1}; tv[17] = '{1, 2198, 1}; tv[18] = '{1, 2199, 1};
    tv[19] = '{1, 4095, 3};
    sm_exp = '{3, 8, 13, 2, 7, 12, 1, 6, 11, 0, 5, 10, 15, 4, 9, 14};

    rst_n = 1'b0;
    valid_data_in = 1'b0; row_addr = '0; col_addr = '0; matrix_element = '0;
    commit = 1'b0; transpose = 1'b0; data_request = 1'b0;
    s_vin = 1'b0; s_row = '0; s_col = '0; s_elem = '0;
    s_commit = 1'b0; s_tr = 1'b0; s_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {valid_data_out, busy, frame_done, bank_ready, commit_drop, sym_out}, 0);
    rst_n = 1'b1;

    @(negedge clk); data_request = 1'b1;
    @(negedge clk); data_request = 1'b0;
    watch_idle(8, saw);
    chk("request_before_commit", saw, 0);

    write_matrix(0);
    pulse_commit(d1);
    chk("first_commit_drop", d1, 0);
    chk("bank_ready_set", bank_ready, 1);
    run_frame(1'b0, 5000);
    check_frame_shape("ident");
    for (int i = 0; i < 20; i++)
      if (tv[i].frame == 0) chk($sformatf("ident_sym%0d", tv[i].idx), cap[tv[i].idx], tv[i].exp);
    chk("ident_full_frame_errs", frame_errs(0, 1'b0), 0);
    chk("idle_after_frame", busy, 0);

    write_matrix(1);
    pulse_commit(d1);
    fork
      run_frame(1'b1, 5000);
      begin
        repeat (100) @(negedge clk);
        transpose = 1'b0;
      end
    join
    chk("transp_len", nvalid, FS);
    for (int i = 0; i < 20; i++)
      if (tv[i].frame == 1) chk($sformatf("transp_sym%0d", tv[i].idx), cap[tv[i].idx], tv[i].exp);
    chk("transp_full_frame_errs", frame_errs(1, 1'b1), 0);

    fork
      run_frame(1'b0, 5000);
      begin
        repeat (10) @(negedge clk);
        data_request = 1'b1;
        @(negedge clk);
        data_request = 1'b0;
        write_matrix(2);
        pulse_commit(d1);
        chk("midframe_commit_drop", d1, 0);
        repeat (5) @(negedge clk);
        pulse_commit(d2);
        chk("second_commit_drop", d2, 1);
        chk("busy_midframe", busy, 1);
      end
    join
    check_frame_shape("midc");
    chk("midc_frame_unchanged", frame_errs(1, 1'b0), 0);
    watch_idle(6, saw);
    chk("busy_request_ignored", saw, 0);
    run_frame(1'b0, 5000);
    chk("swapped_len", nvalid, FS);
    chk("swapped_all_0x55", frame_errs(2, 1'b0), 0);
    chk("bank_ready_sticky", bank_ready, 1);

    @(negedge clk); data_request = 1'b1;
    @(negedge clk); data_request = 1'b0;
    cnt = 0; k = 0;
    while (cnt < 1000 && k < 3000) begin
      @(negedge clk);
      k++;
      if (valid_data_out) cnt++;
    end
    @(negedge clk);
    chk("pre_reset_streaming", valid_data_out, 1);
    #2 rst_n = 1'b0;
    #1 chk("reset_midframe_outputs", {valid_data_out, busy, frame_done, sym_out}, 0);
    chk("reset_clears_ready", bank_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); data_request = 1'b1;
    @(negedge clk); data_request = 1'b0;
    watch_idle(20, saw);
    chk("request_after_reset", saw, 0);

    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      s_vin  = 1'b1;
      s_row  = 2'(e / 4);
      s_col  = 2'(e % 4);
      s_elem = 4'(e * 5 + 3);
    end
    @(negedge clk); s_vin = 1'b0; s_commit = 1'b1;
    @(negedge clk); s_commit = 1'b0; s_req = 1'b1;
    @(negedge clk); s_req = 1'b0;
    cnt = 0; k = 1; first_lat = -1; done_at = -1;
    while (k < 60) begin
      if (s_vout) begin
        if (first_lat < 0) first_lat = k;
        if (cnt < 16) chk($sformatf("small_sym%0d", cnt), s_sym, sm_exp[cnt]);
        cnt++;
        if (s_done) done_at = cnt;
      end else if (first_lat >= 0) break;
      @(negedge clk);
      k++;
    end
    chk("small_latency", first_lat, 2);
    chk("small_len", cnt, 16);
    chk("small_done_pos", done_at, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
